mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Clocking: one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  main clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-004 inst_req  input  1  instruction-fetch read request.
REQ-005 inst_addr  input  32  instruction byte address.
REQ-006 inst_ack  output  1  one-cycle completion pulse for the instruction access.
REQ-007 inst_rdata  output  32  instruction word; valid only while inst_ack=1.
REQ-008 inst_err  output  1  misaligned fetch; valid only while inst_ack=1.
REQ-009 data_req  input  1  data request.
REQ-010 data_we  input  1  1 = write, 0 = read.
REQ-011 data_addr  input  32  data byte address.
REQ-012 data_wdata  input  32  write word.
REQ-013 data_ack  output  1  one-cycle completion pulse for the data access.
REQ-014 data_rdata  output  32  read word; valid only while data_ack=1.
REQ-015 data_err  output  1  misaligned data access; valid only while data_ack=1.
REQ-016 ram_en  output  1  shared single-port RAM access strobe.
REQ-017 ram_we  output  1  RAM write enable.
REQ-018 ram_addr  output  32  RAM word address, {2'b0, addr[31:2]}.
REQ-019 ram_din  output  32  RAM write data.
REQ-020 ram_dout  input  32  RAM read data; synchronous, valid the cycle after ram_en.
REQ-021 stat_clr  input  1  synchronous clear of the stall counters.
REQ-022 inst_stall_cnt  output  16  count of instruction-requester wait cycles.
REQ-023 data_stall_cnt  output  16  count of data-requester wait cycles.

Function
REQ-024 FSM states: IDLE, WAIT_I, WAIT_D; the FSM holds a last_grant register (INST/DATA).
REQ-025 In IDLE with only one req high, that requester is granted; with both high, the requester not equal to last_grant is granted; with neither high, the FSM stays in IDLE.
REQ-026 Grant cycle (IDLE): ram_addr, ram_din and ram_we come combinationally from the granted requester; ram_en=1; last_grant updates; next state is WAIT_I or WAIT_D.
REQ-027 ram_we = granted data_we and is never 1 for an instruction grant.
REQ-028 Outside a grant cycle, ram_en=0 and ram_we=0; ram_addr and ram_din are don't-care.
REQ-029 WAIT_x: the corresponding ack=1 for exactly one cycle, rdata = ram_dout (0 for writes and for errors), then the FSM returns to IDLE.
REQ-030 Latency: request sampled in IDLE in cycle N, ack in cycle N+1; throughput is at most one access per 2 cycles.
REQ-031 Misalignment: a granted access with addr[1:0] != 0 gets ram_en=0 and ram_we=0, follows the normal WAIT path, and completes with err=1 and rdata=0.
REQ-032 A non-granted ack and err are 0; both acks are never 1 in the same cycle.
REQ-033 Requesters hold req, addr, we and wdata stable until ack; the arbiter samples only in the grant cycle.
REQ-034 A req dropped after grant does not abort the access: a write is still performed and the ack is still issued.
REQ-035 Stall counters: each counter increments when its req=1 and its ack=0; 16-bit, saturating at 0xFFFF with no wrap.
REQ-036 stat_clr=1 zeroes both counters and wins over a simultaneous increment.

Reset
REQ-037 rst=0 immediately forces: state=IDLE, last_grant=INST, both counters=0, both acks=0, both errs=0, both rdata=0, ram_en=0, ram_we=0.
REQ-038 ram_en and ram_we are gated to 0 for as long as rst=0, regardless of req.
REQ-039 Reset asserted in WAIT_x drops the pending ack; after release, the FSM restarts in IDLE and the first tie goes to DATA.

Verification
REQ-040 Single fetch: inst_req=1, inst_addr=0x8, ram_dout=0x1234 -> ram_en=1, ram_addr=0x2 in cycle N; inst_ack=1, inst_rdata=0x1234 in N+1.
REQ-041 Tie after reset: both req=1 continuously -> grants alternate D,I,D,I, with acks at cycles 1,3,5,7.
REQ-042 Write: data_req=1, we=1, addr=0x10, wdata=0xCAFE -> ram_we=1, ram_addr=0x4, ram_din=0xCAFE for one cycle; data_ack next cycle with data_rdata=0.
REQ-043 Misaligned: data_addr=0x6 -> ram_en=0; data_ack=1, data_err=1 next cycle.
REQ-044 Stall and saturation: data holds the port while inst_req=1 -> inst_stall_cnt increments once per waiting cycle; when forced to 0xFFFF it stays there; stat_clr with a concurrent stall -> 0.
REQ-045 Reset mid-access: rst=0 during WAIT_D -> data_ack stays 0, ram_we=0 at once; after release, a new request is acked in 2 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous single-port RAM between an instruction
// fetch port and a data port, with fair tie-breaking and saturating stall counters.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ack,
  output logic [31:0] inst_rdata,
  output logic        inst_err,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  input  logic        stat_clr,
  output logic [15:0] inst_stall_cnt,
  output logic [15:0] data_stall_cnt,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester raises req with stable fields; the access is granted in an
  // IDLE cycle and completes with a single-cycle ack on the next cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_I = 2'd1, WAIT_D = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        last_data_q, last_data_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [15:0] inst_cnt_q, inst_cnt_d;
  logic [15:0] data_cnt_q, data_cnt_d;

  logic        grant_any;
  logic        grant_data;
  logic        misaligned;
  logic [31:0] sel_addr;

  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    err_d       = err_q;
    we_d        = we_q;
    grant_any   = 1'b0;
    grant_data  = 1'b0;
    sel_addr    = inst_addr;
    misaligned  = 1'b0;
    case (state_q)
      IDLE: begin
        if (inst_req || data_req) begin
          grant_any   = 1'b1;
          // On a tie the port that did not win last time gets the RAM.
          grant_data  = data_req && (!inst_req || !last_data_q);
          sel_addr    = grant_data ? data_addr : inst_addr;
          misaligned  = (sel_addr[1:0] != 2'b00);
          err_d       = misaligned;
          we_d        = grant_data && data_we;
          last_data_d = grant_data;
          state_d     = grant_data ? WAIT_D : WAIT_I;
        end
      end
      WAIT_I:  state_d = IDLE;
      WAIT_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The RAM strobe is gated by reset so nothing reaches memory while rst is low.
  assign ram_en   = rst && grant_any && !misaligned;
  assign ram_we   = ram_en && grant_data && data_we;
  assign ram_addr = {2'b00, sel_addr[31:2]};
  assign ram_din  = data_wdata;

  assign inst_ack   = (state_q == WAIT_I);
  assign inst_err   = inst_ack && err_q;
  assign inst_rdata = (inst_ack && !err_q) ? ram_dout : 32'd0;
  assign data_ack   = (state_q == WAIT_D);
  assign data_err   = data_ack && err_q;
  assign data_rdata = (data_ack && !err_q && !we_q) ? ram_dout : 32'd0;

  always_comb begin
    inst_cnt_d = inst_cnt_q;
    data_cnt_d = data_cnt_q;
    if (stat_clr) begin
      inst_cnt_d = 16'd0;
      data_cnt_d = 16'd0;
    end else begin
      if (inst_req && !inst_ack && inst_cnt_q != 16'hFFFF) inst_cnt_d = inst_cnt_q + 16'd1;
      if (data_req && !data_ack && data_cnt_q != 16'hFFFF) data_cnt_d = data_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_data_q <= 1'b0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      inst_cnt_q  <= 16'd0;
      data_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      err_q       <= err_d;
      we_q        <= we_d;
      inst_cnt_q  <= inst_cnt_d;
      data_cnt_q  <= data_cnt_d;
    end
  end

  assign inst_stall_cnt = inst_cnt_q;
  assign data_stall_cnt = data_cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model of grants, completions and stall
// counts is checked against the DUT every cycle, plus directed scenarios with literals.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic        inst_err;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        data_err;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        stat_clr;
  logic [15:0] inst_stall_cnt;
  logic [15:0] data_stall_cnt;
  logic [1:0]  dbg_state;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack),
    .inst_rdata(inst_rdata), .inst_err(inst_err),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
    .data_err(data_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .stat_clr(stat_clr),
    .inst_stall_cnt(inst_stall_cnt), .data_stall_cnt(data_stall_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // transaction model: one outstanding access at most, plus whose turn a tie is
  bit          m_pend;
  bit          m_pend_data;
  bit          m_pend_err;
  bit          m_pend_we;
  bit          m_last_data;
  logic [15:0] m_icnt;
  logic [15:0] m_dcnt;
  bit          chk_cnt;

  // values observed at the last compare, for directed literal checks
  logic        s_iack, s_dack, s_ierr, s_derr, s_en, s_we;
  logic [31:0] s_ird, s_drd, s_addr, s_din;
  bit          last_iack, last_dack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare at the falling edge, then advance the model at the rising edge.
  task automatic step();
    bit          g_valid, g_data, g_mis;
    logic [31:0] g_addr;
    logic        e_iack, e_dack, e_ierr, e_derr, e_en, e_we;
    logic [31:0] e_ird, e_drd;
    @(negedge clk);
    if (!rst) begin
      m_pend = 0; m_last_data = 0; m_icnt = 16'd0; m_dcnt = 16'd0;
    end
    e_iack = 0; e_dack = 0; e_ierr = 0; e_derr = 0; e_en = 0; e_we = 0;
    e_ird = 32'd0; e_drd = 32'd0;
    g_valid = 0; g_data = 0; g_mis = 0; g_addr = 32'd0;
    if (m_pend) begin
      if (m_pend_data) begin
        e_dack = 1; e_derr = m_pend_err;
        e_drd = (m_pend_err || m_pend_we) ? 32'd0 : ram_dout;
      end else begin
        e_iack = 1; e_ierr = m_pend_err;
        e_ird = m_pend_err ? 32'd0 : ram_dout;
      end
    end else if (rst && (inst_req || data_req)) begin
      g_valid = 1;
      g_data  = data_req && (!inst_req || !m_last_data);
      g_addr  = g_data ? data_addr : inst_addr;
      g_mis   = (g_addr[1:0] != 2'b00);
      e_en    = !g_mis;
      e_we    = g_data && data_we && !g_mis;
    end
    check("inst_ack", 32'(inst_ack), 32'(e_iack));
    check("data_ack", 32'(data_ack), 32'(e_dack));
    check("inst_err", 32'(inst_err), 32'(e_ierr));
    check("data_err", 32'(data_err), 32'(e_derr));
    check("ram_en", 32'(ram_en), 32'(e_en));
    check("ram_we", 32'(ram_we), 32'(e_we));
    if (e_iack || !rst) check("inst_rdata", inst_rdata, e_ird);
    if (e_dack || !rst) check("data_rdata", data_rdata, e_drd);
    if (e_en) check("ram_addr", ram_addr, {2'b00, g_addr[31:2]});
    if (e_we) check("ram_din", ram_din, data_wdata);
    if (chk_cnt) begin
      check("inst_stall_cnt", 32'(inst_stall_cnt), 32'(m_icnt));
      check("data_stall_cnt", 32'(data_stall_cnt), 32'(m_dcnt));
    end
    s_iack = inst_ack; s_dack = data_ack; s_ierr = inst_err; s_derr = data_err;
    s_en = ram_en; s_we = ram_we; s_ird = inst_rdata; s_drd = data_rdata;
    s_addr = ram_addr; s_din = ram_din;
    last_iack = e_iack; last_dack = e_dack;
    @(posedge clk);
    if (rst) begin
      if (stat_clr) begin
        m_icnt = 16'd0; m_dcnt = 16'd0;
      end else begin
        if (inst_req && !e_iack && m_icnt != 16'hFFFF) m_icnt++;
        if (data_req && !e_dack && m_dcnt != 16'hFFFF) m_dcnt++;
      end
      if (m_pend) m_pend = 0;
      else if (g_valid) begin
        m_pend = 1; m_pend_data = g_data; m_pend_err = g_mis;
        m_pend_we = g_data && data_we; m_last_data = g_data;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
    if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    total = 0; bad = 0; chk_cnt = 1;
    m_pend = 0; m_pend_data = 0; m_pend_err = 0; m_pend_we = 0; m_last_data = 0;
    m_icnt = 16'd0; m_dcnt = 16'd0;
    rst = 1'b0; stat_clr = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h40;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h20; data_wdata = 32'h0;
    ram_dout = 32'hA5A5A5A5;

    // reset holds the RAM strobe low even with both requests up
    step(); step();
    check("reset ram_en", 32'(s_en), 32'd0);
    check("reset ram_we", 32'(s_we), 32'd0);
    check("reset counters", {inst_stall_cnt, data_stall_cnt}, 32'd0);

    // tie after reset alternates D,I,D,I with acks on cycles 1,3,5,7
    data_we = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("tie data_ack", 32'(s_dack), (k == 1 || k == 5) ? 32'd1 : 32'd0);
      check("tie inst_ack", 32'(s_iack), (k == 3 || k == 7) ? 32'd1 : 32'd0);
      if (k == 0) check("tie first addr", s_addr, 32'h8);
      if (k == 2) check("tie second addr", s_addr, 32'h10);
    end
    inst_req = 1'b0; data_req = 1'b0;
    step();

    // single aligned fetch
    inst_req = 1'b1; inst_addr = 32'h8; ram_dout = 32'h1234;
    step();
    check("fetch ram_en", 32'(s_en), 32'd1);
    check("fetch ram_addr", s_addr, 32'h2);
    check("fetch ram_we", 32'(s_we), 32'd0);
    step();
    check("fetch ack", 32'(s_iack), 32'd1);
    check("fetch rdata", s_ird, 32'h1234);
    inst_req = 1'b0;

    // write: read data returns zero on completion
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h10; data_wdata = 32'hCAFE;
    ram_dout = 32'hDEADBEEF;
    step();
    check("write ram_we", 32'(s_we), 32'd1);
    check("write ram_addr", s_addr, 32'h4);
    check("write ram_din", s_din, 32'hCAFE);
    step();
    check("write ack", 32'(s_dack), 32'd1);
    check("write rdata", s_drd, 32'd0);
    data_req = 1'b0;

    // misaligned read never touches the RAM and completes with an error
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h6;
    step();
    check("misaligned ram_en", 32'(s_en), 32'd0);
    step();
    check("misaligned ack", 32'(s_dack), 32'd1);
    check("misaligned err", 32'(s_derr), 32'd1);
    check("misaligned rdata", s_drd, 32'd0);
    data_req = 1'b0;

    // stall counting while data holds the port
    stat_clr = 1'b1; step(); stat_clr = 1'b0;
    data_req = 1'b1; data_addr = 32'h30; step();
    inst_req = 1'b1; inst_addr = 32'h34; step();
    data_req = 1'b0; step();
    step();
    inst_req = 1'b0;
    check("stall inst count", 32'(inst_stall_cnt), 32'd2);
    check("stall data count", 32'(data_stall_cnt), 32'd1);

    // saturation at 0xFFFF, then clear beats a simultaneous stall
    inst_req = 1'b1; data_req = 1'b1;
    chk_cnt = 0;
    force dut.inst_cnt_q = 16'hFFFF;
    step();
    release dut.inst_cnt_q;
    m_icnt = 16'hFFFF;
    chk_cnt = 1;
    for (int k = 0; k < 4; k++) step();
    check("saturated inst count", 32'(inst_stall_cnt), 32'hFFFF);
    stat_clr = 1'b1; step(); stat_clr = 1'b0;
    check("clear inst count", 32'(inst_stall_cnt), 32'd0);
    check("clear data count", 32'(data_stall_cnt), 32'd0);
    inst_req = 1'b0; data_req = 1'b0;
    step(); step();

    // reset during a pending write drops the ack; the first tie afterwards goes to data
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h20; data_wdata = 32'h55;
    step();
    rst = 1'b0;
    #1;
    check("reset now data_ack", 32'(data_ack), 32'd0);
    check("reset now ram_we", 32'(ram_we), 32'd0);
    step();
    check("reset wait data_ack", 32'(s_dack), 32'd0);
    rst = 1'b1; inst_req = 1'b1; inst_addr = 32'h44;
    step();
    check("post reset grant data", s_addr, 32'h8);
    check("post reset ram_we", 32'(s_we), 32'd1);
    step();
    check("post reset ack", 32'(s_dack), 32'd1);
    inst_req = 1'b0; data_req = 1'b0;
    step();

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      ram_dout = $urandom;
      stat_clr = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 399) != 0);
      if (!inst_req || last_iack) begin
        inst_req = $urandom_range(0, 1) == 1;
        inst_addr = rand_addr();
      end else if (m_pend && !m_pend_data && $urandom_range(0, 5) == 0) begin
        inst_req = 1'b0;
      end
      if (!data_req || last_dack) begin
        data_req = $urandom_range(0, 1) == 1;
        data_we = $urandom_range(0, 1) == 1;
        data_addr = rand_addr();
        data_wdata = $urandom;
      end else if (m_pend && m_pend_data && $urandom_range(0, 5) == 0) begin
        data_req = 1'b0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
